adc_serial_sequencer: RTL and testbench
=======================================

// Module: adc_serial_sequencer
// PURPOSE
//  Multi-channel serial-slave readout sequencer for AD7643-class SAR ADCs; generalises the fixed 2-ch/18-bit loop.
//  Issues CNVSTN, waits for all BUSY low, clocks NCH SDOUT lines in parallel on a shared SCLK, and writes one
//  truncated word per channel to sample RAM at a programmed period. Sits between the USB command decoder
//  (START/STOP/NSAMP) and the dual-port sample memories read back by the FT600 transfer path.
// PARAMETERS
//  NCH       2    number of ADC channels (shared CNVSTN/SCLK, one SDOUT/BUSY each)
//  NBITS     18   bits shifted per conversion, MSB first
//  OUTW      16   stored width; word = shift[NBITS-1 -: OUTW] (drop NBITS-OUTW LSBs); OUTW<=NBITS
//  AW        14   sample address width; RAM depth 2**AW
//  SCLK_DIV  1    SCLK half-period in CLK cycles (>=1)
//  CNV_W     2    CNVSTN low width in CLK cycles (>=1)
//  BUSY_TMO  255  max CLK cycles waiting for BUSY low before timeout
// PORTS
//  CLK       in   1          system clock; all logic on posedge
//  RSTN      in   1          async active-low reset
//  START     in   1          1-cycle pulse: clear addr/counters/flags, begin acquisition
//  STOP      in   1          1-cycle pulse: finish current conversion, then idle
//  PERIOD    in   16         CLK cycles between CNVSTN falling edges; sampled at START
//  NSAMP     in   AW+1       conversions to take; 0 = continuous until STOP; sampled at START
//  CNVSTN    out  1          convert start to all ADCs, active low
//  SCLK      out  1          shared serial clock, idles low
//  BUSY      in   NCH        ADC busy, active high, one per channel
//  SDOUT     in   NCH        serial data, one per channel
//  WE        out  1          sample write strobe, 1 cycle
//  WADDR     out  AW         write address
//  WDATA     out  NCH*OUTW   ch k at [k*OUTW +: OUTW]
//  RUN       out  1          high from START until return to IDLE
//  DONE      out  1          1-cycle pulse on return to IDLE
//  OVERRUN   out  1          sticky: readout exceeded PERIOD
//  TMO       out  1          sticky: BUSY timeout occurred
//  WRAPPED   out  1          sticky: WADDR wrapped 2**AW-1 -> 0
// BEHAVIOUR
//  Reset (async, RSTN=0): state IDLE; CNVSTN=1, SCLK=0, WE=0, WADDR=0, WDATA=0, RUN=0, DONE=0, flags=0.
//  FSM: IDLE -> CONV -> WAITB -> SHIFT -> STORE -> HOLD -> CONV | IDLE.
//  IDLE: on START latch PERIOD/NSAMP, WADDR=0, clear sticky flags, sample count=0, RUN=1, -> CONV next cycle.
//  CONV: CNVSTN=0 for CNV_W cycles; period counter restarts on first CONV cycle; -> WAITB.
//  WAITB: first cycle ignored (BUSY rise latency); -> SHIFT when &(~BUSY); after BUSY_TMO cycles set TMO, -> SHIFT.
//  SHIFT: NBITS SCLK pulses, each SCLK_DIV cycles low then SCLK_DIV high; on the cycle SCLK goes 1->0
//   shift_k <= {shift_k[NBITS-2:0], SDOUT[k]}; SCLK=0 after last bit; length = 2*SCLK_DIV*NBITS cycles.
//  STORE: WE=1 one cycle with WADDR=current addr, WDATA=truncated words; shift regs cleared; count+1.
//  HOLD: wait until period counter reaches PERIOD-1, -> CONV. If STORE ends at/after PERIOD-1, set OVERRUN, -> CONV
//   immediately (no HOLD cycle). PERIOD<CNV_W+2 treated as overrun every sample.
//  WADDR increments the cycle after WE; at 2**AW-1 it wraps to 0 and sets WRAPPED; data overwritten.
//  Termination: after STORE, if (NSAMP!=0 and count==NSAMP) or STOP seen -> IDLE, RUN=0, DONE=1 one cycle.
//   STOP latched in any non-IDLE state; current conversion always completes and is stored. STOP in IDLE ignored.
//  START while RUN=1: ignored. START and STOP same cycle in IDLE: start, then exactly one sample, then DONE.
//  NSAMP > 2**AW allowed (wraps). Counters: period 16 bit, sample count AW+1 bit.
//  RSTN low mid-SHIFT: immediate IDLE, CNVSTN=1, SCLK=0, partial word discarded, no WE.
// TESTING
//  1 NCH=2, NBITS=18, SCLK_DIV=1, PERIOD=100, NSAMP=4; SDOUT models 0x3FFFC/0x00004 -> 4 WE at 100-cycle
//    spacing, WDATA ch0=0xFFFF ch1=0x0001, WADDR 0..3, DONE once, OVERRUN=0.
//  2 PERIOD=30 with SCLK_DIV=1 (readout ~42 cycles) -> OVERRUN=1, CNVSTN falls the cycle after each STORE.
//  3 BUSY ch1 stuck high -> TMO=1 after 255 wait cycles, sample still stored, run continues.
//  4 AW=4, NSAMP=20 -> 20 writes, WADDR wraps 15->0, WRAPPED=1, last WADDR=3.
//  5 NSAMP=0, STOP mid-SHIFT of sample 7 -> sample 7 stored, DONE next cycle, no further CNVSTN.
//  6 RSTN asserted mid-SHIFT -> all outputs at reset values asynchronously; new START restarts at WADDR=0.

Source files
------------

// File: rtl/adc_serial_sequencer.sv
// Multi-channel readout sequencer for serial-slave SAR ADCs.
// Converts, waits for BUSY, shifts NCH lanes in parallel, stores a word per period.
module adc_serial_sequencer #(
   parameter int NCH      = 2,
   parameter int NBITS    = 18,
   parameter int OUTW     = 16,
   parameter int AW       = 14,
   parameter int SCLK_DIV = 1,
   parameter int CNV_W    = 2,
   parameter int BUSY_TMO = 255
) (
   input  logic                CLK,
   input  logic                RSTN,
   input  logic                START,
   input  logic                STOP,
   input  logic [15:0]         PERIOD,
   input  logic [AW:0]         NSAMP,
   output logic                CNVSTN,
   output logic                SCLK,
   input  logic [NCH-1:0]      BUSY,
   input  logic [NCH-1:0]      SDOUT,
   output logic                WE,
   output logic [AW-1:0]       WADDR,
   output logic [NCH*OUTW-1:0] WDATA,
   output logic                RUN,
   output logic                DONE,
   output logic                OVERRUN,
   output logic                TMO,
   output logic                WRAPPED
);

   localparam int BW = $clog2(NBITS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONV,
      S_WAITB,
      S_SHIFT,
      S_STORE,
      S_HOLD
   } state_t;

   state_t           state;
   state_t           nxt;
   logic [15:0]      tcnt;
   logic [15:0]      pcnt;
   logic [15:0]      period_q;
   logic [AW:0]      nsamp_q;
   logic [AW:0]      cnt;
   logic [AW:0]      cnt_inc;
   logic [BW-1:0]    bcnt;
   logic [NBITS-1:0] sh [NCH];
   logic             sclk_q;
   logic             stop_q;
   logic             half_end;
   logic             fall;
   logic             last_bit;
   logic             term;
   logic             late;
   logic             busy_clr;
   logic             tmo_hit;

   assign busy_clr = &(~BUSY);
   assign half_end = (tcnt == 16'(SCLK_DIV - 1));
   assign fall     = (state == S_SHIFT) && half_end && sclk_q;
   assign last_bit = (bcnt == BW'(NBITS - 1));
   assign cnt_inc  = cnt + 1'b1;
   assign term     = ((nsamp_q != '0) && (cnt_inc == nsamp_q))
                     || stop_q || STOP;
   assign late     = ({1'b0, pcnt} + 17'd1) >= {1'b0, period_q};
   assign tmo_hit  = (state == S_WAITB) && (tcnt != '0) && !busy_clr
                     && (tcnt >= 16'(BUSY_TMO - 1));
   assign SCLK     = sclk_q;

   // state register
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) state <= S_IDLE;
      else       state <= nxt;
   end

   // next state, convert strobe and write strobe
   always_comb begin
      nxt    = state;
      CNVSTN = 1'b1;
      WE     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (START) nxt = S_CONV;
         end
         S_CONV: begin
            CNVSTN = 1'b0;
            if (tcnt >= 16'(CNV_W - 1)) nxt = S_WAITB;
         end
         S_WAITB: begin
            if (tcnt != '0 && (busy_clr || tmo_hit)) nxt = S_SHIFT;
         end
         S_SHIFT: begin
            if (fall && last_bit) nxt = S_STORE;
         end
         S_STORE: begin
            WE = 1'b1;
            if (term)      nxt = S_IDLE;
            else if (late) nxt = S_CONV;
            else           nxt = S_HOLD;
         end
         S_HOLD: begin
            if (late) nxt = S_CONV;
         end
         default: nxt = S_IDLE;
      endcase
   end

   // phase timer per state, period timer from first CONV cycle
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         tcnt <= '0;
         pcnt <= '0;
      end else begin
         if (nxt != state || (state == S_SHIFT && half_end))
            tcnt <= '0;
         else if (tcnt != '1)
            tcnt <= tcnt + 1'b1;
         if (state == S_CONV && tcnt == '0)
            pcnt <= 16'd1;
         else if (pcnt != '1)
            pcnt <= pcnt + 1'b1;
      end
   end

   // run control, serial shifting, address and sticky flags
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         sclk_q   <= 1'b0;
         bcnt     <= '0;
         stop_q   <= 1'b0;
         period_q <= '0;
         nsamp_q  <= '0;
         cnt      <= '0;
         WADDR    <= '0;
         RUN      <= 1'b0;
         DONE     <= 1'b0;
         OVERRUN  <= 1'b0;
         TMO      <= 1'b0;
         WRAPPED  <= 1'b0;
         for (int k = 0; k < NCH; k++) sh[k] <= '0;
      end else begin
         DONE <= 1'b0;
         if (state == S_IDLE) stop_q <= START & STOP;
         else                 stop_q <= stop_q | STOP;
         unique case (state)
            S_IDLE: begin
               if (START) begin
                  period_q <= PERIOD;
                  nsamp_q  <= NSAMP;
                  WADDR    <= '0;
                  cnt      <= '0;
                  OVERRUN  <= 1'b0;
                  TMO      <= 1'b0;
                  WRAPPED  <= 1'b0;
                  RUN      <= 1'b1;
               end
            end
            S_WAITB: begin
               if (tmo_hit) TMO <= 1'b1;
            end
            S_SHIFT: begin
               if (half_end) begin
                  sclk_q <= ~sclk_q;
                  if (sclk_q) begin
                     bcnt <= last_bit ? '0 : bcnt + 1'b1;
                     for (int k = 0; k < NCH; k++)
                        sh[k] <= {sh[k][NBITS-2:0], SDOUT[k]};
                  end
               end
            end
            S_STORE: begin
               for (int k = 0; k < NCH; k++) sh[k] <= '0;
               cnt   <= cnt_inc;
               WADDR <= WADDR + 1'b1;
               if (&WADDR) WRAPPED <= 1'b1;
               if (term) begin
                  RUN  <= 1'b0;
                  DONE <= 1'b1;
               end else if (late) begin
                  OVERRUN <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // truncated words: keep the top OUTW bits of each lane
   always_comb begin
      WDATA = '0;
      for (int k = 0; k < NCH; k++)
         WDATA[k*OUTW +: OUTW] = sh[k][NBITS-1 -: OUTW];
   end

endmodule

// File: tb/tb_adc_serial_sequencer.sv
// Bench for adc_serial_sequencer: behavioural ADC pair plus
// table, hand-written and random acquisition runs.
module tb_adc_serial_sequencer;

   localparam int NCH = 2;
   localparam int NBITS = 18;
   localparam int OUTW = 16;
   localparam int AW = 4;
   localparam int SCLK_DIV = 1;
   localparam int CNV_W = 2;
   localparam int BUSY_TMO = 255;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic start = 1'b0;
   logic stop = 1'b0;
   logic [15:0] period = '0;
   logic [AW:0] nsamp = '0;
   logic cnvstn, sclk, we, run, done, overrun, tmo, wrapped;
   logic [NCH-1:0] busy, sdout;
   logic [AW-1:0] waddr;
   logic [NCH*OUTW-1:0] wdata;

   always #5 clk = ~clk;

   adc_serial_sequencer #(
      .NCH(NCH), .NBITS(NBITS), .OUTW(OUTW), .AW(AW),
      .SCLK_DIV(SCLK_DIV), .CNV_W(CNV_W), .BUSY_TMO(BUSY_TMO)
   ) dut (
      .CLK(clk), .RSTN(rstn), .START(start), .STOP(stop),
      .PERIOD(period), .NSAMP(nsamp), .CNVSTN(cnvstn), .SCLK(sclk),
      .BUSY(busy), .SDOUT(sdout), .WE(we), .WADDR(waddr), .WDATA(wdata),
      .RUN(run), .DONE(done), .OVERRUN(overrun), .TMO(tmo),
      .WRAPPED(wrapped)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] tr(input logic [17:0] w);
      return w[17:2];
   endfunction

   // ADC model and event recorder
   int cyc = 0;
   int bitidx = 0;
   int busy_cnt = 0;
   int cbusy = 6;
   logic cnv_q = 1'b1;
   logic sclk_q = 1'b0;
   logic [1:0] stuck = '0;
   bit fixed = 1'b1;
   logic [17:0] fw0 = '0;
   logic [17:0] fw1 = '0;
   logic [17:0] w0 = '0;
   logic [17:0] w1 = '0;
   int we_cyc[$];
   int cnv_cyc[$];
   int done_cyc[$];
   logic [AW-1:0] we_addr[$];
   logic [31:0] we_dat[$];
   logic [17:0] wq0[$];
   logic [17:0] wq1[$];
   int b_we, b_cnv, b_done;

   always @(negedge clk) begin
      logic [17:0] a, b;
      cyc <= cyc + 1;
      cnv_q <= cnvstn;
      sclk_q <= sclk;
      if (we) begin
         we_cyc.push_back(cyc);
         we_addr.push_back(waddr);
         we_dat.push_back(wdata);
      end
      if (done) done_cyc.push_back(cyc);
      if (cnv_q && !cnvstn) begin
         a = fixed ? fw0 : 18'($urandom);
         b = fixed ? fw1 : 18'($urandom);
         w0 <= a;
         w1 <= b;
         wq0.push_back(a);
         wq1.push_back(b);
         cnv_cyc.push_back(cyc);
         busy_cnt <= cbusy - 1;
         bitidx <= 0;
      end else begin
         if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
         if (sclk_q && !sclk) bitidx <= bitidx + 1;
      end
   end

   assign busy = stuck | {NCH{busy_cnt != 0}};

   always_comb begin
      sdout = '0;
      if (bitidx < NBITS) begin
         sdout[0] = w0[NBITS-1-bitidx];
         sdout[1] = w1[NBITS-1-bitidx];
      end
   end

   task automatic mark();
      b_we = we_cyc.size();
      b_cnv = cnv_cyc.size();
      b_done = done_cyc.size();
   endtask

   task automatic pulse_start(input int p, input int n, input bit st);
      @(posedge clk); #1;
      period = 16'(p);
      nsamp = (AW+1)'(n);
      start = 1'b1;
      stop = st;
      @(posedge clk); #1;
      start = 1'b0;
      stop = 1'b0;
   endtask

   task automatic pulse_stop();
      @(posedge clk); #1;
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
   endtask

   task automatic wait_done(input int bound, input string nm);
      int k;
      k = 0;
      while (done_cyc.size() == b_done && k < bound) begin
         @(posedge clk);
         k++;
      end
      chk({nm, " done seen"}, 64'(done_cyc.size() > b_done), 1);
   endtask

   task automatic check_run(input string nm, input int n, input int sp,
                            input bit ovr, input bit wrap, input bit etmo,
                            input bit fx, input logic [31:0] fd);
      int nw;
      repeat (100) @(posedge clk);
      @(negedge clk); #1;
      nw = we_cyc.size() - b_we;
      chk({nm, " writes"}, 64'(nw), 64'(n));
      for (int i = 0; i < nw && i < n; i++) begin
         logic [31:0] ed;
         if (fx) ed = fd;
         else if (b_cnv + i < wq0.size())
            ed = {tr(wq1[b_cnv+i]), tr(wq0[b_cnv+i])};
         else ed = '1;
         chk($sformatf("%s addr%0d", nm, i), we_addr[b_we+i], 64'(i % 16));
         chk($sformatf("%s data%0d", nm, i), we_dat[b_we+i], ed);
         if (i > 0) begin
            chk($sformatf("%s spacing%0d", nm, i),
                64'(we_cyc[b_we+i] - we_cyc[b_we+i-1]), 64'(sp));
            if (ovr && b_cnv + i < cnv_cyc.size())
               chk($sformatf("%s cnv after store%0d", nm, i),
                   64'(cnv_cyc[b_cnv+i] - we_cyc[b_we+i-1]), 1);
         end
      end
      chk({nm, " done count"}, 64'(done_cyc.size() - b_done), 1);
      if (nw > 0 && done_cyc.size() > b_done)
         chk({nm, " done timing"},
             64'(done_cyc[b_done] - we_cyc[b_we+nw-1]), 1);
      chk({nm, " conversions"}, 64'(cnv_cyc.size() - b_cnv), 64'(n));
      chk({nm, " flags ovr/tmo/wrap/run"},
          {overrun, tmo, wrapped, run}, {ovr, etmo, wrap, 1'b0});
   endtask

   typedef struct {
      int p;
      int n;
      int c;
      logic [17:0] a0;
      logic [17:0] a1;
      int sp;
      bit ovr;
      bit wrap;
      logic [15:0] d0;
      logic [15:0] d1;
   } vec_t;

   vec_t vt[7];

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k, p, n, c, r;
      bit lt;
      vt[0] = '{100, 4, 6, 18'h3FFFC, 18'h00004, 100, 0, 0, 16'hFFFF, 16'h0001};
      vt[1] = '{30, 3, 6, 18'h2AAAA, 18'h15555, 43, 1, 0, 16'hAAAA, 16'h5555};
      vt[2] = '{43, 3, 6, 18'h3FFFF, 18'h00003, 43, 1, 0, 16'hFFFF, 16'h0000};
      vt[3] = '{44, 3, 6, 18'h12345, 18'h0ABCD, 44, 0, 0, 16'h48D1, 16'h2AF3};
      vt[4] = '{50, 20, 6, 18'h3FFFC, 18'h00004, 50, 0, 1, 16'hFFFF, 16'h0001};
      vt[5] = '{0, 2, 6, 18'h00004, 18'h3FFFC, 43, 1, 0, 16'h0001, 16'hFFFF};
      vt[6] = '{60, 2, 4, 18'h20000, 18'h1FFFF, 60, 0, 0, 16'h8000, 16'h7FFF};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset cnvstn", cnvstn, 1);
      chk("reset strobes", {sclk, we, run, done, overrun, tmo, wrapped}, 0);
      chk("reset waddr", waddr, 0);
      chk("reset wdata", wdata, 0);
      rstn = 1'b1;

      for (int i = 0; i < 7; i++) begin
         fixed = 1'b1;
         fw0 = vt[i].a0;
         fw1 = vt[i].a1;
         cbusy = vt[i].c;
         mark();
         pulse_start(vt[i].p, vt[i].n, 1'b0);
         wait_done(vt[i].n * (vt[i].sp + 100) + 500, $sformatf("vec%0d", i));
         check_run($sformatf("vec%0d", i), vt[i].n, vt[i].sp, vt[i].ovr,
                   vt[i].wrap, 1'b0, 1'b1, {vt[i].d1, vt[i].d0});
      end

      fixed = 1'b1;
      fw0 = 18'h3FFFC;
      fw1 = 18'h00004;
      cbusy = 6;

      pulse_stop();
      mark();
      pulse_start(60, 2, 1'b0);
      wait_done(1000, "idle stop");
      check_run("idle stop", 2, 60, 0, 0, 0, 1, {16'h0001, 16'hFFFF});

      mark();
      pulse_start(60, 0, 1'b1);
      wait_done(1000, "start+stop");
      check_run("start+stop", 1, 60, 0, 0, 0, 1, {16'h0001, 16'hFFFF});

      mark();
      pulse_start(60, 3, 1'b0);
      repeat (70) @(posedge clk);
      pulse_start(30, 1, 1'b0);
      wait_done(1000, "busy start");
      check_run("busy start", 3, 60, 0, 0, 0, 1, {16'h0001, 16'hFFFF});

      stuck = 2'b10;
      mark();
      pulse_start(400, 2, 1'b0);
      wait_done(2000, "timeout");
      check_run("timeout", 2, 400, 0, 0, 1, 1, {16'h0001, 16'hFFFF});
      stuck = 2'b00;

      mark();
      pulse_start(60, 0, 1'b0);
      k = 0;
      while (cnv_cyc.size() - b_cnv < 7 && k < 2000) begin
         @(posedge clk);
         k++;
      end
      chk("stop run seventh conversion", 64'(cnv_cyc.size() - b_cnv >= 7), 1);
      repeat (16) @(posedge clk);
      #1 stop = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
      wait_done(500, "mid-shift stop");
      check_run("mid-shift stop", 7, 60, 0, 0, 0, 1, {16'h0001, 16'hFFFF});

      mark();
      pulse_start(60, 0, 1'b0);
      k = 0;
      while (cnv_cyc.size() - b_cnv < 3 && k < 2000) begin
         @(posedge clk);
         k++;
      end
      repeat (16) @(posedge clk);
      #2;
      chk("pre-reset waddr", waddr, 2);
      rstn = 1'b0;
      #1;
      chk("async reset cnvstn", cnvstn, 1);
      chk("async reset strobes",
          {sclk, we, run, done, overrun, tmo, wrapped}, 0);
      chk("async reset waddr", waddr, 0);
      chk("async reset wdata", wdata, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("aborted run writes", 64'(we_cyc.size() - b_we), 2);
      rstn = 1'b1;
      mark();
      pulse_start(60, 2, 1'b0);
      wait_done(1000, "restart");
      check_run("restart", 2, 60, 0, 0, 0, 1, {16'h0001, 16'hFFFF});

      fixed = 1'b0;
      for (int i = 0; i < 10; i++) begin
         p = $urandom_range(20, 80);
         n = $urandom_range(1, 8);
         c = $urandom_range(4, 10);
         cbusy = c;
         r = c + 2 * SCLK_DIV * NBITS;
         lt = (r >= p - 1);
         mark();
         pulse_start(p, n, 1'b0);
         wait_done(n * 200 + 500, $sformatf("rand%0d", i));
         check_run($sformatf("rand%0d", i), n, lt ? r + 1 : p,
                   lt && n >= 2, n > 16, 1'b0, 1'b0, '0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
